// File: rtl/prod_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with valid/ready on both sides.
// Optional build macro LZB_EN: blank leading zero digits to 4'hF when the result is loaded.
module prod_bcd_conv #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  busy
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [IN_W-1:0] bin_sr;
    logic [BW-1:0]   bcd_sr;
    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   bcd_next;
    logic [BW-1:0]   bcd_load;
    logic [CW-1:0]   cnt;

    // Per-digit +3 correction; digits are independent, no carry between nibbles.
    always_comb begin
        bcd_adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_sr[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
            else
                bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4];
        end
    end

    assign bcd_next = {bcd_adj[BW-2:0], bin_sr[IN_W-1]};

`ifdef LZB_EN
    // Units digit is never blanked, so a zero result still shows a single 0.
    function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] v);
        logic lead;
        lead     = 1'b1;
        blank_lz = v;
        for (int k = DIGITS - 1; k > 0; k--) begin
            if (lead && v[4*k +: 4] == 4'd0)
                blank_lz[4*k +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
    endfunction

    assign bcd_load = blank_lz(bcd_next);
`else
    assign bcd_load = bcd_next;
`endif

    // Gated by rst so the port reads 0 throughout any reset cycle.
    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bin_sr    <= '0;
            bcd_sr    <= '0;
            cnt       <= '0;
            out_bcd   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr <= in_data;
                        bcd_sr <= '0;
                        cnt    <= CW'(IN_W - 1);
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_sr <= bcd_next;
                    bin_sr <= {bin_sr[IN_W-2:0], 1'b0};
                    if (cnt == '0) begin
                        out_bcd   <= bcd_load;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prod_bcd_conv.sv
// Directed self-checking bench for prod_bcd_conv: latency, back-pressure, reset abort, back-to-back, input hold.
module tb_prod_bcd_conv;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_bcd;
    logic        busy;

    int checks = 0;
    int fails  = 0;
    bit mon_en = 1'b0;

`ifdef LZB_EN
    localparam logic [19:0] E6460 = 20'hF6460, E0 = 20'hFFFF0, E65535 = 20'h65535, E9 = 20'hFFFF9;
    localparam logic [19:0] E4321 = 20'hF4321, E100 = 20'hFF100, E99 = 20'hFFF99, E1000 = 20'hF1000;
`else
    localparam logic [19:0] E6460 = 20'h06460, E0 = 20'h00000, E65535 = 20'h65535, E9 = 20'h00009;
    localparam logic [19:0] E4321 = 20'h04321, E100 = 20'h00100, E99 = 20'h00099, E1000 = 20'h01000;
`endif

    prod_bcd_conv #(.IN_W(16), .DIGITS(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Internal BCD register must never hold a non-decimal digit.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (dut.bcd_sr[4*k +: 4] > 4'd9) begin
                    fails++;
                    $display("FAIL digit_range: digit %0d = %h, required <= 9", k, dut.bcd_sr[4*k +: 4]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || out_bcd !== 20'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b bcd=%h busy=%b rdy=%b, required 0 0 0 0", out_valid, out_bcd, busy, in_ready);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b, required 1", in_ready); end
    endtask

    // Accept one word, check latency and result, optionally stall, then handshake.
    task automatic run(input logic [15:0] data, input logic [19:0] exp, input int hold,
                       input bit scramble, input string name);
        int cyc;
        in_data = data; in_valid = 1'b1; out_ready = (hold == 0);
        step();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s_busy: busy=%b rdy=%b, required 1 0", name, busy, in_ready);
        end
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (scramble) in_data = 16'($urandom);
            step();
            cyc++;
        end
        checks++;
        if (cyc != 16) begin fails++; $display("FAIL %s_latency: got %0d cycles, required 16", name, cyc); end
        checks++;
        if (out_bcd !== exp) begin fails++; $display("FAIL %s_result: got %h, required %h", name, out_bcd, exp); end
        for (int i = 0; i < hold; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_bcd !== exp || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL %s_hold%0d: valid=%b bcd=%h rdy=%b, required 1 %h 0", name, i, out_valid, out_bcd, in_ready, exp);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== exp) begin
            fails++;
            $display("FAIL %s_release: valid=%b rdy=%b bcd=%h, required 0 1 %h", name, out_valid, in_ready, out_bcd, exp);
        end
    endtask

    task automatic test_convert();
        run(16'd6460, E6460, 0, 1'b0, "conv6460");
        run(16'd0, E0, 0, 1'b0, "conv0");
        run(16'd65535, E65535, 0, 1'b0, "conv65535");
        run(16'd1000, E1000, 0, 1'b0, "conv1000");
    endtask

    task automatic test_backpressure();
        run(16'd9, E9, 10, 1'b0, "bp9");
        // out_ready while idle must not disturb anything
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_out_ready: valid=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_mid_reset();
        in_data = 16'd1234; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_bcd !== 20'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: valid=%b bcd=%h rdy=%b busy=%b, required 0 0 1 0", out_valid, out_bcd, in_ready, busy);
        end
        run(16'd4321, E4321, 0, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad_rdy;
        in_data = 16'd100; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_data = 16'd99;
        cyc = 0; bad_rdy = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (in_ready !== 1'b0) bad_rdy++;
            step();
            cyc++;
        end
        checks++;
        if (bad_rdy != 0 || cyc != 16) begin
            fails++;
            $display("FAIL b2b_first_timing: ready_leaks=%0d cycles=%0d, required 0 16", bad_rdy, cyc);
        end
        checks++;
        if (out_bcd !== E100) begin fails++; $display("FAIL b2b_first: got %h, required %h", out_bcd, E100); end
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_gap: rdy=%b valid=%b, required 1 0", in_ready, out_valid);
        end
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc != 16 || out_bcd !== E99) begin
            fails++;
            $display("FAIL b2b_second: cycles=%0d bcd=%h, required 16 %h", cyc, out_bcd, E99);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_input_hold();
        run(16'd6460, E6460, 0, 1'b1, "scramble");
    endtask

    initial begin
        test_reset();
        test_convert();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_input_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
